// File: rtl/kbd_spi_tx.sv
// Keyboard-link frame transmitter: serialises {STATUS, KEYS} MSB first on KBD_CLK/KBD_CS/KBD_DI.
// Optional odd-parity trailer bit enabled by defining KBD_SPI_TX_PARITY_EN.
module kbd_spi_tx #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned GAP_MULT = 2
) (
    input  logic        CLK_14MHZ,
    input  logic        RESET,
    input  logic        START,
    input  logic [39:0] KEYS,
    input  logic [7:0]  STATUS,
    output logic        BUSY,
    output logic        DONE,
    output logic        KBD_CLK,
    output logic        KBD_CS,
    output logic        KBD_DI
);

`ifdef KBD_SPI_TX_PARITY_EN
    localparam int unsigned NBITS = 49;
`else
    localparam int unsigned NBITS = 48;
`endif

    localparam logic [7:0]  DIV_LOAD = 8'(CLK_DIV - 1);
    localparam logic [11:0] GAP_LOAD = 12'(GAP_MULT * CLK_DIV - 1);
    localparam logic [5:0]  LAST_BIT = 6'(NBITS - 1);
    localparam logic [5:0]  ALL_BITS = 6'(NBITS);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        GAP
    } state_t;

    state_t             state_q;
    logic [NBITS-2:0]   shift_q;
    logic [5:0]         bit_cnt_q;
    logic [7:0]         div_q;
    logic [11:0]        gap_q;
    logic               busy_q;
    logic               done_q;
    logic               sck_q;
    logic               cs_q;
    logic               di_q;
    logic [NBITS-1:0]   frame_w;

`ifdef KBD_SPI_TX_PARITY_EN
    assign frame_w = {STATUS, KEYS, ~^{STATUS, KEYS}};
`else
    assign frame_w = {STATUS, KEYS};
`endif

    // The MSB goes straight onto KBD_DI at latch time, so only the remaining bits are held.
    always_ff @(posedge CLK_14MHZ) begin
        if (RESET) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            div_q     <= '0;
            gap_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sck_q     <= 1'b0;
            cs_q      <= 1'b1;
            di_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (START) begin
                        shift_q   <= frame_w[NBITS-2:0];
                        di_q      <= frame_w[NBITS-1];
                        cs_q      <= 1'b0;
                        busy_q    <= 1'b1;
                        div_q     <= DIV_LOAD;
                        bit_cnt_q <= '0;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_q == 8'd0) begin
                        sck_q   <= 1'b1;
                        div_q   <= DIV_LOAD;
                        state_q <= SHIFT_HI;
                    end else begin
                        div_q <= div_q - 8'd1;
                    end
                end
                SHIFT_HI: begin
                    if (div_q == 8'd0) begin
                        sck_q     <= 1'b0;
                        div_q     <= DIV_LOAD;
                        bit_cnt_q <= bit_cnt_q + 6'd1;
                        // After the last bit the data line is left alone for the CS-hold phase.
                        if (bit_cnt_q != LAST_BIT) begin
                            di_q    <= shift_q[NBITS-2];
                            shift_q <= shift_q << 1;
                        end
                        state_q <= SHIFT_LO;
                    end else begin
                        div_q <= div_q - 8'd1;
                    end
                end
                SHIFT_LO: begin
                    if (div_q == 8'd0) begin
                        div_q <= DIV_LOAD;
                        if (bit_cnt_q == ALL_BITS) begin
                            cs_q    <= 1'b1;
                            di_q    <= 1'b0;
                            gap_q   <= GAP_LOAD;
                            state_q <= GAP;
                        end else begin
                            sck_q   <= 1'b1;
                            state_q <= SHIFT_HI;
                        end
                    end else begin
                        div_q <= div_q - 8'd1;
                    end
                end
                GAP: begin
                    if (done_q) begin
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (gap_q == 12'd0) begin
                        done_q <= 1'b1;
                    end else begin
                        gap_q <= gap_q - 12'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign KBD_CLK = sck_q;
    assign KBD_CS  = cs_q;
    assign KBD_DI  = di_q;

endmodule

// File: tb/tb_kbd_spi_tx.sv
// Scoreboard bench for kbd_spi_tx: stimulus pushes expected frames, a negedge monitor
// reassembles frames from the serial lines and checks data, edge count and timing.
module tb_kbd_spi_tx;

    localparam int CLK_DIV  = 4;
    localparam int GAP_MULT = 2;
`ifdef KBD_SPI_TX_PARITY_EN
    localparam int NB = 49;
`else
    localparam int NB = 48;
`endif
    localparam int G        = GAP_MULT * CLK_DIV;
    localparam int CS_LOW   = CLK_DIV * (1 + 2 * NB);
    localparam int BUSY_LEN = CS_LOW + G + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [39:0] keys;
    logic [7:0]  status;
    logic        busy, done, kbd_clk, kbd_cs, kbd_di;

    kbd_spi_tx #(.CLK_DIV(CLK_DIV), .GAP_MULT(GAP_MULT)) dut (
        .CLK_14MHZ (clk),
        .RESET     (rst),
        .START     (start),
        .KEYS      (keys),
        .STATUS    (status),
        .BUSY      (busy),
        .DONE      (done),
        .KBD_CLK   (kbd_clk),
        .KBD_CS    (kbd_cs),
        .KBD_DI    (kbd_di)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [48:0] exp_q[$];
    int exp_done     = 0;
    int abort_cs_req = 0;
    int abort_cs_ack = 0;
    int abort_bz_req = 0;
    int abort_bz_ack = 0;

    // monitor state
    logic        prev_cs   = 1'b1;
    logic        prev_sck  = 1'b0;
    logic        prev_busy = 1'b0;
    int          cs_low_len = 0;
    int          edges      = 0;
    logic [48:0] col        = '0;
    int          gap_run    = 0;
    int          gap_wait   = -1;
    bit          have_prev  = 1'b0;
    int          busy_len   = 0;
    int          done_cnt   = 0;

    function automatic void check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // Reference frame: STATUS then KEYS, MSB first, optionally followed by odd parity.
    function automatic logic [48:0] model_frame(input logic [39:0] k, input logic [7:0] s);
        logic [47:0] f;
        f = {s, k};
`ifdef KBD_SPI_TX_PARITY_EN
        return {f, ~^f};
`else
        return {1'b0, f};
`endif
    endfunction

    always @(negedge clk) begin
        logic [48:0] e;
        if (done) begin
            done_cnt++;
            if (gap_wait >= 0) check("done_delay", gap_wait + 1, G);
            else               check("done_outside_gap", done, 0);
            gap_wait = -1;
        end else if (gap_wait >= 0) begin
            gap_wait++;
        end

        if (!kbd_cs) begin
            cs_low_len++;
            if (kbd_clk && !prev_sck) begin
                col = {col[47:0], kbd_di};
                edges++;
            end
        end

        if (kbd_cs && !prev_cs) begin
            check("scoreboard_nonempty", exp_q.size() > 0, 1);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            if (abort_cs_ack != abort_cs_req) begin
                abort_cs_ack++;
                check("abort_truncated", edges < NB, 1);
                have_prev = 1'b0;
                $display("frame aborted after %0d bits", edges);
            end else begin
                check("frame_data", col, e);
                check("rise_edges", edges, NB);
                check("cs_low_len", cs_low_len, CS_LOW);
                gap_wait  = 0;
                have_prev = 1'b1;
                $display("frame data=%h edges=%0d cs_low=%0d", col, edges, cs_low_len);
            end
            cs_low_len = 0;
            edges      = 0;
            col        = '0;
            gap_run    = 0;
        end

        if (!kbd_cs && prev_cs && have_prev) check("cs_gap_min", gap_run >= G, 1);
        if (kbd_cs) gap_run++;

        if (busy) begin
            busy_len++;
        end else if (prev_busy) begin
            if (abort_bz_ack != abort_bz_req) abort_bz_ack++;
            else                              check("busy_len", busy_len, BUSY_LEN);
            busy_len = 0;
        end

        prev_cs   = kbd_cs;
        prev_sck  = kbd_clk;
        prev_busy = busy;
    end

    // Issued at a negedge while idle; accepted on the following posedge.
    task automatic send(input logic [39:0] k, input logic [7:0] s);
        keys   = k;
        status = s;
        start  = 1'b1;
        exp_q.push_back(model_frame(k, s));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", busy, 0);
        @(negedge clk);
    endtask

    initial begin
        int bad;
        int d0;
        int rises;
        logic pb;
        rst    = 1'b1;
        start  = 1'b0;
        keys   = '0;
        status = '0;
        @(negedge clk);
        check("reset_state", {kbd_cs, kbd_clk, kbd_di, busy, done}, 5'b10000);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if ({kbd_cs, kbd_clk, kbd_di, busy, done} != 5'b10000) bad++;
        end
        check("idle_outputs", bad, 0);

        // Directed frame, inputs change after latch, spurious START mid-frame.
        d0 = done_cnt;
        send(40'hFF_FFFF_FFFE, 8'h5F);
        exp_done++;
        keys = '0;
        repeat (98) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        check("single_done", done_cnt - d0, 1);

        // All keys pressed, status zero (parity bit 1 when enabled).
        send(40'h0, 8'h00);
        exp_done++;
        wait_idle();

        for (int i = 0; i < 6; i++) begin
            send({$urandom(), $urandom()}, 8'($urandom()));
            exp_done++;
            repeat ($urandom_range(20, 300)) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            wait_idle();
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        // START held high: three back-to-back frames.
        d0     = done_cnt;
        keys   = {$urandom(), $urandom()};
        status = 8'($urandom());
        for (int i = 0; i < 3; i++) exp_q.push_back(model_frame(keys, status));
        exp_done += 3;
        start = 1'b1;
        rises = 0;
        pb    = busy;
        for (int n = 0; n < 3000 && rises < 3; n++) begin
            @(negedge clk);
            if (busy && !pb) rises++;
            pb = busy;
        end
        start = 1'b0;
        check("hold_frames_started", rises, 3);
        wait_idle();
        check("hold_done_count", done_cnt - d0, 3);

        // Reset around bit 20, then a clean frame.
        d0 = done_cnt;
        send({$urandom(), $urandom()}, 8'($urandom()));
        for (int n = 0; n < 1000 && edges < 20; n++) begin
            @(negedge clk);
            #1;
        end
        check("reached_bit20", edges >= 20, 1);
        rst = 1'b1;
        abort_cs_req++;
        abort_bz_req++;
        @(negedge clk);
        check("reset_midframe_cs", kbd_cs, 1);
        check("reset_midframe_busy", busy, 0);
        check("reset_midframe_sck", kbd_clk, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("reset_no_done", done_cnt - d0, 0);
        send({$urandom(), $urandom()}, 8'($urandom()));
        exp_done++;
        wait_idle();
        check("post_reset_done", done_cnt - d0, 1);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("done_total", done_cnt, exp_done);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
